// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and the
// NULL instruction presented to decode while no instruction is valid.
package ifu_pkg;

  // Fetch FSM: issue a request, wait for its data, or discard a stale response
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  // NULL class instruction (bits[27:26]=11) and its decode slice
  localparam logic [31:0] NULL_INST   = 32'h0C00_0000;
  localparam logic [11:0] NULL_DECODE = 12'hC00;

  // ARM R15 reads as the instruction address plus 8
  localparam int unsigned PC_READ_OFFSET = 8;

  // Byte stride between sequential instruction words
  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/inst_fetch_unit_fetch_buffer.sv
// Prefetch FIFO holding {inst, pc} pairs. Flush empties it in one cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buffer
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;
  logic              w_clear;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_clear   = reset || flush;
  assign w_do_pop  = pop && !empty;
  // A push into a full buffer is only legal when the head leaves the same cycle
  assign w_do_push = push && (!full || w_do_pop);

  // Pointer and occupancy tracking; flush and reset both empty the buffer
  always_ff @(posedge clock) begin
    if (w_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are qualified by the count so no reset is needed
  always_ff @(posedge clock) begin
    if (w_do_push && !w_clear) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one word request at a
// time to instruction memory, buffers returned words and presents the head
// with its PC, PC+8 and decode slice. Branch redirects flush the stream.
// Optional build macro FETCH_BYPASS_EN forwards a returning word straight to
// the outputs when the buffer is empty, saving one cycle of latency.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           BUF_DEPTH  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  stall,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic [ADDR_WIDTH-1:0] pc_plus8,
  output logic [11:0]           decode_bits
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned PAY_W = INST_WIDTH + ADDR_WIDTH;

  fetch_state_e          r_state;
  fetch_state_e          w_next_state;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_req_pc;

  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_bypass;
  logic                  w_bypass_take;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic [PAY_W-1:0]      w_head;
  logic [INST_WIDTH-1:0] w_out_inst;
  logic [ADDR_WIDTH-1:0] w_out_pc;

  fetch_buffer #(
    .DEPTH  (BUF_DEPTH),
    .DATA_W (PAY_W)
  ) u_fetch_buffer (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (branch_taken),
    .din   ({imem_rdata, r_req_pc}),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

`ifdef FETCH_BYPASS_EN
  // Returning word goes straight to decode when nothing is queued ahead of it
  assign w_bypass      = !reset && (r_state == S_WAIT) && imem_rvalid &&
                         !branch_taken && w_empty;
  assign w_bypass_take = w_bypass && !stall;
`else
  assign w_bypass      = 1'b0;
  assign w_bypass_take = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_REQ;
    else       r_state <= w_next_state;
  end

  // FSM next state; a redirect turns any in-flight response into a stale one
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_REQ: begin
        if (branch_taken)  w_next_state = w_accept ? S_DROP : S_REQ;
        else if (w_accept) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)       w_next_state = S_REQ;
        else if (branch_taken) w_next_state = S_DROP;
      end
      S_DROP: begin
        if (imem_rvalid) w_next_state = S_REQ;
      end
      default: w_next_state = S_REQ;
    endcase
  end

  // FSM outputs: request only while the buffer has room, push live responses
  always_comb begin
    imem_req = 1'b0;
    w_push   = 1'b0;
    unique case (r_state)
      S_REQ:   imem_req = !reset && (w_count < CNT_W'(BUF_DEPTH));
      S_WAIT:  w_push   = imem_rvalid && !branch_taken && !w_full && !w_bypass_take;
      default: ;
    endcase
  end

  assign w_accept  = imem_req && imem_ready;
  assign w_pop     = !w_empty && !stall && !branch_taken;
  assign imem_addr = r_fetch_pc;

  // Fetch PC and the address of the outstanding request
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
    end else begin
      if (w_accept) r_req_pc <= r_fetch_pc;
      if (branch_taken)  r_fetch_pc <= branch_target & ~ADDR_WIDTH'(3);
      else if (w_accept) r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(INST_BYTES);
    end
  end

  // Select the presented instruction: buffer head, or the forwarded response
  always_comb begin
    inst_valid = !w_empty;
    w_out_inst = w_head[PAY_W-1:ADDR_WIDTH];
    w_out_pc   = w_head[ADDR_WIDTH-1:0];
    if (w_bypass) begin
      inst_valid = 1'b1;
      w_out_inst = imem_rdata;
      w_out_pc   = r_req_pc;
    end
  end

  assign inst_out    = inst_valid ? w_out_inst : INST_WIDTH'(NULL_INST);
  assign inst_pc     = inst_valid ? w_out_pc : '0;
  assign pc_plus8    = inst_pc + ADDR_WIDTH'(PC_READ_OFFSET);
  assign decode_bits = {inst_out[27:20], inst_out[7:4]};

endmodule
